// File: rtl/shift_exec_stage.sv
// Two-stage execute shifter for SLL/SRL/SRA: a coarse shift by a multiple of 8,
// then a fine shift by 0..7, with valid/ready backpressure and flush.
module shift_exec_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;

  logic [1:0]       s1_op;
  logic [2:0]       s1_fine;
  logic [XLEN-1:0]  s1_val;
  logic             s1_sign;
  logic [TAG_W-1:0] s1_tag;

  logic            c_left, c_sra;
  logic [4:0]      c_amt;
  logic [XLEN:0]   c_ext;
  logic [XLEN-1:0] c_val;
  logic            f_left, f_sra;
  logic [XLEN:0]   f_ext;
  logic [XLEN-1:0] f_res;

  assign s2_adv    = !vld_pipe[2] | out_ready;
  assign s1_adv    = !vld_pipe[1] | s2_adv;
  assign in_ready  = s1_adv & !flush;
  assign out_valid = vld_pipe[2];

  // Right shifts run on a 33-bit value whose extra top bit is the fill bit,
  // so one arithmetic shift serves both SRL (fill 0) and SRA (fill sign).
  always_comb begin
    c_left = !in_op[0];
    c_sra  = in_op == 2'b11;
    c_amt  = {in_shamt[4:3], 3'b000};
    c_ext  = $signed({c_sra & in_a[XLEN-1], in_a}) >>> c_amt;
    c_val  = c_left ? (in_a << c_amt) : c_ext[XLEN-1:0];
  end

  always_comb begin
    f_left = !s1_op[0];
    f_sra  = s1_op == 2'b11;
    f_ext  = $signed({f_sra & s1_sign, s1_val}) >>> s1_fine;
    f_res  = f_left ? (s1_val << s1_fine) : f_ext[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv) vld_pipe[1] <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op      <= '0;
      s1_fine    <= '0;
      s1_val     <= '0;
      s1_sign    <= 1'b0;
      s1_tag     <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b1;
    end else begin
      if (in_valid && in_ready) begin
        s1_op   <= in_op;
        s1_fine <= in_shamt[2:0];
        s1_val  <= c_val;
        s1_sign <= in_a[XLEN-1];
        s1_tag  <= in_tag;
      end
      // Output registers only move when stage 2 can advance, so a stalled
      // result stays stable on out_*.
      if (s2_adv && vld_pipe[1]) begin
        out_result <= f_res;
        out_tag    <= s1_tag;
        out_zero   <= f_res == '0;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: vector table, hand-written stall/flush/reset
// sequences and random ops, all checked through an expected-result queue.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;

  shift_exec_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_lat  = 1'b0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-by-bit reference for the random section.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input int sh);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (!op[0]) r[i] = (i - sh >= 0) ? a[i - sh] : 1'b0;
      else        r[i] = (i + sh < 32) ? a[i + sh] : (op[1] & a[31]);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output side: every transfer pops and compares one expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result %h tag %0d, want no output", out_result, out_tag);
      end else begin
        e = sb.pop_front();
        check("result", out_result, e.res);
        check("tag", 32'(out_tag), 32'(e.tag));
        check("zero", 32'(out_zero), 32'(e.res == 32'h0));
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                      input logic [4:0] tag, input logic [31:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_shamt = sh;
    in_tag   = tag;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, want 1", n);
    end else begin
      sb.push_back('{exp, tag, cyc});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{2'b00, 32'h1, 5'(i), 32'h1 << i};
    tbl[8]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[9]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    tbl[10] = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[11] = '{2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    tbl[12] = '{2'b10, 32'hF000_000F, 5'd4,  32'h0000_00F0};
    tbl[13] = '{2'b11, 32'hF000_000F, 5'd12, 32'hFFFF_0000};
    tbl[14] = '{2'b00, 32'h1234_5678, 5'd20, 32'h6780_0000};
    tbl[15] = '{2'b01, 32'h1234_5678, 5'd8,  32'h0012_3456};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back table vectors, full throughput, latency checked.
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    for (int i = 0; i < 16; i++) send(tbl[i].op, tbl[i].a, tbl[i].sh, 5'(i), tbl[i].exp);
    drain();

    // Backpressure: two ops fill the pipe, the third must wait.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(2'b01, 32'hAAAA_AAAA, 5'd0, 5'd20, 32'hAAAA_AAAA);
    send(2'b01, 32'hAAAA_AAAA, 5'd1, 5'd21, 32'h5555_5555);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_shamt = 5'd2;
    in_tag   = 5'd22;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", out_result, 32'hAAAA_AAAA);
      check("bp_hold_tag", 32'(out_tag), 32'd20);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b01, 32'hAAAA_AAAA, 5'd2, 5'd22, 32'h2AAA_AAAA);
    send(2'b01, 32'hAAAA_AAAA, 5'd3, 5'd23, 32'h1555_5555);
    drain();

    // Flush with both stages full and a new op presented in the same cycle.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_00FF, 5'd4, 5'd1, 32'h0000_0FF0);
    send(2'b00, 32'h0000_00FF, 5'd8, 5'd2, 32'h0000_FF00);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_a     = 32'hDEAD_BEEF;
    in_shamt = 5'd4;
    in_tag   = 5'd3;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    check("flush_no_accept", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    @(negedge clk);
    send(2'b11, 32'h8000_0000, 5'd4, 5'd4, 32'hF800_0000);
    drain();

    // Asynchronous reset between edges with both stages full.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    send(2'b00, 32'h0000_0003, 5'd9,  5'd9,  32'h0000_0600);
    send(2'b00, 32'h0000_0003, 5'd10, 5'd10, 32'h0000_0C00);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_result", out_result, 32'h0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_out_zero", 32'(out_zero), 32'd1);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    send(2'b01, 32'h0000_F000, 5'd12, 5'd17, 32'h0000_000F);
    drain();

    // Random ops with random output backpressure.
    chk_lat  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [4:0]  sh;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      sh = 5'($urandom_range(0, 31));
      send(op, a, sh, 5'(i), model(op, a, int'(sh)));
    end
    drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
